// File: rtl/mtr_multi.sv
// rtl/mtr_multi.sv - bank of accounting counters with 1 us interval timer and vectored interrupts
// Register-bus block: per-counter event/time counting, interval timer, prioritised interrupt flags.
module mtr_multi #(
  parameter int NCNT     = 4,
  parameter int W        = 17,
  parameter int IW       = 12,
  parameter int PRESCALE = 33
) (
  input  logic            clk,
  input  logic            RESET_N,
  input  logic            WR,
  input  logic [3:0]      ADDR,
  input  logic [W-1:0]    WDATA,
  input  logic            RD,
  output logic [W-1:0]    RDATA,
  input  logic [NCNT-1:0] EVT,
  input  logic            QUAL,
  output logic            INT_REQ,
  output logic [3:0]      INT_VEC,
  input  logic            INT_ACK,
  output logic            TICK
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]   pre_q, pre_d;
  logic            tick_q, tick_d;
  logic [W-1:0]    cnt_q [NCNT];
  logic [W-1:0]    cnt_d [NCNT];
  logic [NCNT-1:0] en_q, en_d;
  logic [NCNT-1:0] mode_q, mode_d;
  logic [NCNT-1:0] pend_q, pend_d;
  logic            iv_on_q, iv_on_d;
  logic [IW-1:0]   period_q, period_d;
  logic [IW-1:0]   icnt_q, icnt_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    rdata_q, rdata_d;

  logic            wr_ctl, wr_tim, wr_sts, ack_fire;
  logic [NCNT-1:0] pend_set, pend_clr;
  logic            done_set, done_clr, ovf_set, ovf_clr;
  logic [IW:0]     icnt_nxt;
  logic [W-1:0]    rd_val;
  logic            int_req;
  logic [3:0]      int_vec;

  // Lowest pending counter wins, then interval done, then interval overflow.
  always_comb begin
    int_req = (|pend_q) | done_q | ovf_q;
    int_vec = 4'd0;
    if (ovf_q)  int_vec = 4'(NCNT + 1);
    if (done_q) int_vec = 4'(NCNT);
    for (int i = NCNT - 1; i >= 0; i--) begin
      if (pend_q[i]) int_vec = 4'(i);
    end
  end

  always_comb begin
    wr_ctl   = WR && (ADDR == 4'd8);
    wr_tim   = WR && (ADDR == 4'd9);
    wr_sts   = WR && (ADDR == 4'd10);
    ack_fire = INT_ACK && int_req;

    pre_d  = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
    tick_d = (pre_q == PW'(PRESCALE - 1));

    // A bus write to a counter overrides any increment in the same cycle.
    pend_set = '0;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (WR && (ADDR == 4'(i))) begin
        cnt_d[i] = WDATA;
      end else if (en_q[i] && QUAL && (mode_q[i] ? tick_q : EVT[i])) begin
        cnt_d[i]    = cnt_q[i] + W'(1);
        pend_set[i] = &cnt_q[i];
      end
    end

    en_d   = en_q;
    mode_d = mode_q;
    if (wr_ctl) begin
      en_d   = WDATA[NCNT-1:0];
      mode_d = WDATA[2*NCNT-1:NCNT];
    end

    iv_on_d  = iv_on_q;
    period_d = period_q;
    icnt_d   = icnt_q;
    done_set = 1'b0;
    ovf_set  = 1'b0;
    icnt_nxt = {1'b0, icnt_q} + (IW+1)'(1);
    if (wr_tim) begin
      iv_on_d  = WDATA[IW];
      period_d = WDATA[IW-1:0];
      icnt_d   = '0;
    end else if (iv_on_q && tick_q) begin
      if ((period_q != '0) && (icnt_nxt == {1'b0, period_q})) begin
        icnt_d   = '0;
        done_set = 1'b1;
      end else begin
        icnt_d  = icnt_nxt[IW-1:0];
        ovf_set = icnt_nxt[IW];
      end
    end

    pend_clr = wr_sts ? WDATA[NCNT-1:0] : '0;
    done_clr = wr_sts && WDATA[NCNT];
    ovf_clr  = wr_sts && WDATA[NCNT+1];
    if (ack_fire) begin
      for (int i = 0; i < NCNT; i++) begin
        if (int_vec == 4'(i)) pend_clr[i] = 1'b1;
      end
      if (int_vec == 4'(NCNT))     done_clr = 1'b1;
      if (int_vec == 4'(NCNT + 1)) ovf_clr  = 1'b1;
    end
    // Sets dominate clears so a simultaneous event is never lost.
    pend_d = (pend_q & ~pend_clr) | pend_set;
    done_d = (done_q & ~done_clr) | done_set;
    ovf_d  = (ovf_q & ~ovf_clr) | ovf_set;

    rd_val = '0;
    case (ADDR)
      4'd8:    rd_val = W'({mode_q, en_q});
      4'd9:    rd_val = W'({iv_on_q, period_q});
      4'd10:   rd_val = W'({ovf_q, done_q, pend_q});
      4'd11:   rd_val = W'(icnt_q);
      default: rd_val = '0;
    endcase
    for (int i = 0; i < NCNT; i++) begin
      if (ADDR == 4'(i)) rd_val = cnt_q[i];
    end
    rdata_d = RD ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q    <= '0;
      tick_q   <= 1'b0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      iv_on_q  <= 1'b0;
      period_q <= '0;
      icnt_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      en_q     <= en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      iv_on_q  <= iv_on_d;
      period_q <= period_d;
      icnt_q   <= icnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign RDATA   = rdata_q;
  assign TICK    = tick_q;
  assign INT_REQ = int_req;
  assign INT_VEC = int_vec;

endmodule

// File: tb/tb_mtr_multi.sv
// tb/tb_mtr_multi.sv - self-checking bench for mtr_multi
// Table vectors, directed corner sequences and random traffic against a behavioural model.
module tb_mtr_multi;

  localparam int NC = 4;
  localparam int PS = 33;
  localparam int CMAX = 131072;
  localparam int IMAX = 4096;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        WR = 1'b0, RD = 1'b0, QUAL = 1'b0, INT_ACK = 1'b0;
  logic [3:0]  ADDR = '0;
  logic [16:0] WDATA = '0;
  logic [3:0]  EVT = '0;
  logic [16:0] RDATA;
  logic        INT_REQ, TICK;
  logic [3:0]  INT_VEC;

  logic        f_wr = 1'b0, f_rd = 1'b0;
  logic [3:0]  f_addr = '0;
  logic [16:0] f_wdata = '0;
  logic [16:0] f_rdata;
  logic        f_req, f_tick;
  logic [3:0]  f_vec;

  int nchk = 0;
  int nerr = 0;

  // behavioural model state
  int m_cnt [NC];
  int m_en, m_mode, m_pend, m_done, m_ovf, m_iv, m_per, m_icnt, m_rdata, m_n, m_tick;

  always #5 clk = ~clk;

  mtr_multi dut (
    .clk(clk), .RESET_N(RESET_N), .WR(WR), .ADDR(ADDR), .WDATA(WDATA), .RD(RD),
    .RDATA(RDATA), .EVT(EVT), .QUAL(QUAL), .INT_REQ(INT_REQ), .INT_VEC(INT_VEC),
    .INT_ACK(INT_ACK), .TICK(TICK)
  );

  mtr_multi #(.PRESCALE(2)) u_fast (
    .clk(clk), .RESET_N(RESET_N), .WR(f_wr), .ADDR(f_addr), .WDATA(f_wdata), .RD(f_rd),
    .RDATA(f_rdata), .EVT(4'b0000), .QUAL(1'b0), .INT_REQ(f_req), .INT_VEC(f_vec),
    .INT_ACK(1'b0), .TICK(f_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_req();
    return (m_pend != 0 || m_done != 0 || m_ovf != 0) ? 1 : 0;
  endfunction

  function automatic int m_vec();
    for (int i = 0; i < NC; i++) if (((m_pend >> i) & 1) != 0) return i;
    if (m_done != 0) return NC;
    if (m_ovf != 0) return NC + 1;
    return 0;
  endfunction

  function automatic int m_read(input int a);
    if (a < NC) return m_cnt[a];
    case (a)
      8:  return m_en | (m_mode << NC);
      9:  return (m_iv << 12) | m_per;
      10: return m_pend | (m_done << NC) | (m_ovf << (NC + 1));
      11: return m_icnt;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_en = 0; m_mode = 0; m_pend = 0; m_done = 0; m_ovf = 0;
    m_iv = 0; m_per = 0; m_icnt = 0; m_rdata = 0; m_n = 0; m_tick = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int a, wd, vec, pset, dset, oset, pclr, dclr, oclr, nxt;
    a = int'(ADDR); wd = int'(WDATA); vec = m_vec();
    pset = 0; dset = 0; oset = 0;
    if (RD) m_rdata = m_read(a);
    for (int i = 0; i < NC; i++) begin
      if (WR && a == i) m_cnt[i] = wd;
      else if (((m_en >> i) & 1) != 0 && QUAL &&
               ((((m_mode >> i) & 1) != 0) ? (m_tick != 0) : (EVT[i] == 1'b1))) begin
        m_cnt[i] = (m_cnt[i] + 1) % CMAX;
        if (m_cnt[i] == 0) pset |= (1 << i);
      end
    end
    if (WR && a == 9) begin
      m_iv = (wd >> 12) & 1; m_per = wd % IMAX; m_icnt = 0;
    end else if (m_iv != 0 && m_tick != 0) begin
      nxt = m_icnt + 1;
      if (m_per != 0 && nxt == m_per) begin m_icnt = 0; dset = 1; end
      else begin m_icnt = nxt % IMAX; if (m_icnt == 0) oset = 1; end
    end
    if (WR && a == 8) begin m_en = wd & 15; m_mode = (wd >> NC) & 15; end
    pclr = 0; dclr = 0; oclr = 0;
    if (WR && a == 10) begin pclr = wd & 15; dclr = (wd >> NC) & 1; oclr = (wd >> (NC + 1)) & 1; end
    if (INT_ACK && m_req() != 0) begin
      if (vec < NC) pclr |= (1 << vec);
      else if (vec == NC) dclr = 1;
      else oclr = 1;
    end
    m_pend = (m_pend & ~pclr) | pset;
    m_done = (dclr != 0 ? 0 : m_done) | dset;
    m_ovf  = (oclr != 0 ? 0 : m_ovf) | oset;
    m_n++;
    m_tick = (m_n % PS == 0) ? 1 : 0;
  endtask

  task automatic cyc(input logic wr, input int a, input int wd, input logic rd,
                     input int ev, input logic q, input logic ak);
    WR = wr; ADDR = 4'(a); WDATA = 17'(wd); RD = rd; EVT = 4'(ev); QUAL = q; INT_ACK = ak;
    model_step();
    @(posedge clk); #1;
    chk("model_rdata", int'(RDATA), m_rdata);
    chk("model_int_req", int'(INT_REQ), m_req());
    chk("model_int_vec", int'(INT_VEC), m_vec());
    chk("model_tick", int'(TICK), m_tick);
    WR = 1'b0; RD = 1'b0; EVT = '0; INT_ACK = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 1'b0, 0, QUAL, 1'b0);
  endtask

  task automatic wr_reg(input int a, input int d);
    cyc(1'b1, a, d, 1'b0, 0, QUAL, 1'b0);
  endtask

  task automatic rd_reg(input string name, input int a, input int exp);
    cyc(1'b0, a, 0, 1'b1, 0, QUAL, 1'b0);
    chk(name, int'(RDATA), exp);
  endtask

  task automatic do_reset();
    WR = 1'b0; RD = 1'b0; EVT = '0; INT_ACK = 1'b0; QUAL = 1'b0;
    f_wr = 1'b0; f_rd = 1'b0;
    RESET_N = 1'b0;
    #2;
    chk("rst_rdata", int'(RDATA), 0);
    chk("rst_int_req", int'(INT_REQ), 0);
    chk("rst_int_vec", int'(INT_VEC), 0);
    chk("rst_tick", int'(TICK), 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    RESET_N = 1'b1;
  endtask

  typedef struct {
    logic wr; int a; int wd; logic rd; int ev; logic q; logic ak;
    int e_rd; int e_req; int e_vec;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int n, ticks, ft, pick, a, wd;

    @(posedge clk); #1;
    do_reset();

    // reset state and first tick position
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      idle(1);
      if (TICK) begin n = k; break; end
    end
    chk("first_tick_cycle", n, PS);
    for (int k = 0; k < 16; k++) rd_reg("reset_read", k, 0);
    chk("reset_int_req", int'(INT_REQ), 0);

    // table: event counting, qualifier, write/read collisions, wrap and ack
    do_reset();
    tbl.push_back('{1'b1, 8, 1,       1'b0, 0, 1'b1, 1'b0, 0,   0, 0});
    for (int k = 0; k < 5; k++)
      tbl.push_back('{1'b0, 0, 0,     1'b0, 1, 1'b1, 1'b0, 0,   0, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b1, 0, 1'b1, 1'b0, 5,   0, 0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{1'b0, 0, 0,     1'b0, 1, 1'b0, 1'b0, 5,   0, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b1, 0, 1'b0, 1'b0, 5,   0, 0});
    tbl.push_back('{1'b1, 0, 100,     1'b0, 1, 1'b1, 1'b0, 5,   0, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b1, 1, 1'b1, 1'b0, 100, 0, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b1, 0, 1'b1, 1'b0, 101, 0, 0});
    tbl.push_back('{1'b0, 8, 0,       1'b1, 0, 1'b1, 1'b0, 1,   0, 0});
    tbl.push_back('{1'b0, 12, 0,      1'b1, 0, 1'b1, 1'b0, 0,   0, 0});
    tbl.push_back('{1'b1, 0, 'h1FFFF, 1'b0, 0, 1'b1, 1'b0, 0,   0, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b0, 1, 1'b1, 1'b0, 0,   1, 0});
    tbl.push_back('{1'b0, 10, 0,      1'b1, 0, 1'b1, 1'b0, 1,   1, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b0, 0, 1'b1, 1'b1, 1,   0, 0});
    tbl.push_back('{1'b0, 0, 0,       1'b1, 0, 1'b1, 1'b0, 0,   0, 0});
    foreach (tbl[r]) begin
      cyc(tbl[r].wr, tbl[r].a, tbl[r].wd, tbl[r].rd, tbl[r].ev, tbl[r].q, tbl[r].ak);
      chk("tbl_rdata", int'(RDATA), tbl[r].e_rd);
      chk("tbl_int_req", int'(INT_REQ), tbl[r].e_req);
      chk("tbl_int_vec", int'(INT_VEC), tbl[r].e_vec);
    end

    // time-mode wrap on counter 1 after two ticks
    do_reset();
    QUAL = 1'b1;
    wr_reg(1, 'h1FFFE);
    wr_reg(8, 'h22);
    ticks = int'(TICK);
    for (int k = 0; k < 120; k++) begin
      idle(1);
      if (INT_REQ) break;
      if (TICK) ticks++;
    end
    chk("time_wrap_req", int'(INT_REQ), 1);
    chk("time_wrap_ticks", ticks, 2);
    chk("time_wrap_vec", int'(INT_VEC), 1);
    rd_reg("time_wrap_cnt", 1, 0);
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    chk("time_wrap_ack", int'(INT_REQ), 0);

    // interval period 3
    do_reset();
    QUAL = 1'b1;
    wr_reg(9, (1 << 12) | 3);
    ticks = int'(TICK);
    for (int k = 0; k < 200; k++) begin
      idle(1);
      if (INT_REQ) break;
      if (TICK) ticks++;
    end
    chk("iv_done_req", int'(INT_REQ), 1);
    chk("iv_done_ticks", ticks, 3);
    chk("iv_done_vec", int'(INT_VEC), NC);
    rd_reg("iv_icnt", 11, 0);
    rd_reg("iv_status", 10, 'h10);
    wr_reg(9, 0);

    // PERIOD=0 wraps after 4096 ticks on the fast-prescaler instance
    f_wr = 1'b1; f_addr = 4'd9; f_wdata = 17'(1 << 12);
    idle(1);
    f_wr = 1'b0;
    ft = int'(f_tick);
    for (int k = 0; k < 9000; k++) begin
      idle(1);
      if (f_req) break;
      if (f_tick) ft++;
    end
    chk("ovf_req", int'(f_req), 1);
    chk("ovf_ticks", ft, 4096);
    chk("ovf_vec", int'(f_vec), NC + 1);
    f_rd = 1'b1; f_addr = 4'd10;
    idle(1);
    f_rd = 1'b0;
    chk("ovf_status", int'(f_rdata), 'h20);

    // priority order under successive acks, then W1C vs wrap
    do_reset();
    QUAL = 1'b1;
    wr_reg(0, 'h1FFFF);
    wr_reg(2, 'h1FFFF);
    wr_reg(8, 'h5);
    wr_reg(9, (1 << 12) | 1);
    cyc(1'b0, 0, 0, 1'b0, 5, 1'b1, 1'b0);
    idle(40);
    wr_reg(9, 0);
    rd_reg("prio_status", 10, 'h15);
    chk("prio_vec0", int'(INT_VEC), 0);
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    chk("prio_vec2", int'(INT_VEC), 2);
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    chk("prio_vec4", int'(INT_VEC), NC);
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    chk("prio_idle_req", int'(INT_REQ), 0);
    wr_reg(0, 'h1FFFF);
    cyc(1'b1, 10, 1, 1'b0, 1, 1'b1, 1'b0);
    chk("w1c_vs_set_req", int'(INT_REQ), 1);
    chk("w1c_vs_set_vec", int'(INT_VEC), 0);
    wr_reg(10, 1);
    chk("w1c_clear", int'(INT_REQ), 0);

    // asynchronous reset in the middle of counting
    do_reset();
    QUAL = 1'b1;
    wr_reg(8, 1);
    wr_reg(0, 'h1FFFF);
    cyc(1'b0, 0, 0, 1'b0, 1, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1, 1'b1, 1'b0);
    chk("pre_rst_rdata", int'(RDATA), 1);
    chk("pre_rst_req", int'(INT_REQ), 1);
    EVT = 4'b0001;
    do_reset();
    QUAL = 1'b1;
    rd_reg("post_rst_cnt0", 0, 0);
    rd_reg("post_rst_ctl", 8, 0);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      pick = int'($urandom_range(0, 7));
      a = (pick < 4) ? pick : (pick == 4) ? 8 : (pick == 5) ? 9 : (pick == 6) ? 10 : int'($urandom_range(0, 15));
      if (a < NC) wd = ($urandom_range(0, 1) == 1) ? ('h1FFFF - int'($urandom_range(0, 2))) : int'($urandom);
      else if (a == 9) wd = (int'($urandom_range(0, 1)) << 12) | int'($urandom_range(0, 5));
      else wd = int'($urandom);
      cyc(($urandom_range(0, 4) == 0), a, wd, ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
